// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    // Bit counter must hold the value WIDTH itself, not just WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a 4-bit digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    always_comb begin
        d_o = d_i;
        if (d_i >= ADJ_THRESH) begin
            d_o = d_i + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with valid/ready on both sides.
// Optional leading-zero blanking mask (digit_en) is compiled in with BIN2BCD_LZB_EN.
module bin_to_bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  error
`ifdef BIN2BCD_LZB_EN
    ,
    output logic [DIGITS-1:0]     digit_en
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned BW = 4 * DIGITS;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [BW-1:0]        acc_q, acc_d;
    logic [BW-1:0]        adj;
    logic                 err_q, err_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW+WIDTH-1:0]  nxt;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (acc_q[4*g +: 4]),
            .d_o (adj[4*g +: 4])
        );
    end

    // Adjusted accumulator and shift register move left together as one word.
    assign nxt = {adj[BW-2:0], shift_q, 1'b0};

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = b;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = nxt[BW+WIDTH-1:WIDTH];
                shift_d = nxt[WIDTH-1:0];
                err_d   = err_q | adj[BW-1];
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd       = acc_q;
    assign error     = err_q;

`ifdef BIN2BCD_LZB_EN
    logic [DIGITS-1:0] en_d, en_q;
    logic              any_nz;

    // Scan from the top digit down; digit 0 always shows so zero displays as '0'.
    always_comb begin
        en_d   = '0;
        any_nz = 1'b0;
        for (int unsigned i = DIGITS; i > 0; i--) begin
            any_nz    = any_nz | (acc_d[4*(i-1) +: 4] != 4'd0);
            en_d[i-1] = any_nz;
        end
        en_d[0] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= '0;
        end else if (state_q == SHIFT && state_d == DONE) begin
            en_q <= en_d;
        end
    end

    assign digit_en = en_q;
`endif

endmodule
